// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forwarding control for the 5-stage RV32I core
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  ex_rs1_addr_i,
    input  logic [4:0]  ex_rs2_addr_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_rd_wren_i,
    input  logic        ex_is_load_i,
    input  logic [4:0]  mem_rd_addr_i,
    input  logic        mem_rd_wren_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic        wb_rd_wren_i,
    input  logic        ex_redirect_i,
    input  logic        lsu_req_i,
    input  logic        lsu_ack_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        id_ex_en_o,
    output logic        ex_mem_en_o,
    output logic        mem_wb_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic [1:0]  fwd_a_sel_o,
    output logic [1:0]  fwd_b_sel_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_timeout_q, mem_timeout_d;
    logic [31:0]   stall_cnt_q, stall_cnt_d;
    logic [31:0]   flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic load_use;
    logic wait_last;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_rd_wren_i && mem_rd_addr_i != 5'd0 && mem_rd_addr_i == src)
            return 2'b01;
        else if (wb_rd_wren_i && wb_rd_addr_i != 5'd0 && wb_rd_addr_i == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        wait_last = (wait_cnt_q == WAIT_LAST);
        freeze    = ((state_q == RUN) && lsu_req_i && !lsu_ack_i) ||
                    ((state_q == MEM_WAIT) && !lsu_ack_i && !wait_last);
        load_use  = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_used_i && id_rs1_addr_i == ex_rd_addr_i) ||
                     (id_rs2_used_i && id_rs2_addr_i == ex_rd_addr_i));

        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        flush_cnt_d   = flush_cnt_q;

        case (state_q)
            RUN: begin
                if (lsu_req_i && !lsu_ack_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (lsu_ack_i) begin
                    state_d = RUN;
                end else if (wait_last) begin
                    // Forced release: let the pipe move and remember the lost access.
                    state_d       = RUN;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: state_d = RUN;
        endcase

        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        id_ex_en_o    = 1'b0;
        ex_mem_en_o   = 1'b0;
        mem_wb_en_o   = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        fwd_a_sel_o   = 2'b00;
        fwd_b_sel_o   = 2'b00;

        if (reset_ni) begin
            fwd_a_sel_o = fwd_sel(ex_rs1_addr_i);
            fwd_b_sel_o = fwd_sel(ex_rs2_addr_i);
            if (freeze) begin
                pc_en_o = 1'b0;
            end else if (ex_redirect_i) begin
                pc_en_o       = 1'b1;
                if_id_en_o    = 1'b1;
                id_ex_en_o    = 1'b1;
                ex_mem_en_o   = 1'b1;
                mem_wb_en_o   = 1'b1;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                flush_cnt_d   = flush_cnt_q + 32'd1;
            end else if (load_use) begin
                id_ex_en_o    = 1'b1;
                id_ex_flush_o = 1'b1;
                ex_mem_en_o   = 1'b1;
                mem_wb_en_o   = 1'b1;
            end else begin
                pc_en_o     = 1'b1;
                if_id_en_o  = 1'b1;
                id_ex_en_o  = 1'b1;
                ex_mem_en_o = 1'b1;
                mem_wb_en_o = 1'b1;
            end
        end

        stall_cnt_d = pc_en_o ? stall_cnt_q : stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout_o = mem_timeout_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the 5-stage RV32I core. Drives the enable/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. Freezes the whole pipe while a multi-cycle data-memory access is outstanding, inserts load-use bubbles, and flushes the front end on EX-stage redirects. Also produces the EX operand forwarding selects and two performance counters.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive freeze cycles for one data-memory access before forced release (≥2).
- clk_i  in  1  clock, all state on rising edge
- reset_ni  in  1  synchronous, active-low reset
- id_rs1_addr_i, id_rs2_addr_i  in  5 each  source registers of instruction in ID
- id_rs1_used_i, id_rs2_used_i  in  1 each  ID instruction reads rs1/rs2
- ex_rs1_addr_i, ex_rs2_addr_i  in  5 each  source registers of instruction in EX
- ex_rd_addr_i, ex_rd_wren_i, ex_is_load_i  in  5/1/1  destination info of EX instruction
- mem_rd_addr_i, mem_rd_wren_i  in  5/1  destination info of MEM instruction
- wb_rd_addr_i, wb_rd_wren_i  in  5/1  destination info of WB instruction
- ex_redirect_i  in  1  EX branch/jump redirects the PC this cycle
- lsu_req_i  in  1  MEM instruction needs data memory; held while frozen
- lsu_ack_i  in  1  data memory completes the access this cycle
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  stage register load enables
- if_id_flush_o, id_ex_flush_o  out  1 each  load a NOP into the register; only asserted together with its enable
- fwd_a_sel_o, fwd_b_sel_o  out  2 each  EX operand source: 00 regfile, 01 EX/MEM ALU result, 10 WB data
- mem_timeout_o  out  1  sticky: a data-memory access timed out
- stall_cnt_o  out  32  cycles with pc_en_o=0
- flush_cnt_o  out  32  accepted redirects

## Operation
- FSM states: RUN, MEM_WAIT. wait_cnt counts MEM_WAIT cycles.
- Freeze condition F = (RUN & lsu_req_i & !lsu_ack_i) | (MEM_WAIT & !lsu_ack_i & wait_cnt != MEM_TIMEOUT-1).
- Priority per cycle: freeze > redirect > load-use > normal.
- Freeze: all five enables 0, both flushes 0. Redirect and load-use are ignored (their inputs are held because the pipe is frozen).
- Redirect (ex_redirect_i): all enables 1, if_id_flush_o=1, id_ex_flush_o=1; flush_cnt_o increments.
- Load-use: ex_is_load_i & ex_rd_wren_i & ex_rd_addr_i!=0 & ((id_rs1_used_i & rs1 match) | (id_rs2_used_i & rs2 match)). Outputs: pc_en_o=0, if_id_en_o=0, id_ex_en_o=1 with id_ex_flush_o=1, ex_mem_en_o=1, mem_wb_en_o=1.
- Normal: all enables 1, flushes 0.
- Transitions: RUN→MEM_WAIT on lsu_req_i & !lsu_ack_i (wait_cnt←0). MEM_WAIT→RUN on lsu_ack_i, or on wait_cnt==MEM_TIMEOUT-1 without ack (forced release; mem_timeout_o←1). Otherwise wait_cnt increments.
- Forwarding (combinational, per operand): select 01 if mem_rd_wren_i & mem_rd_addr_i!=0 & addr match. Else select 10 if wb_rd_wren_i & wb_rd_addr_i!=0 & addr match. Else 00. MEM has priority over WB.
- Counters: 32-bit, wrap from 0xFFFFFFFF to 0. stall_cnt_o increments on every non-reset cycle with pc_en_o=0.

## Timing
- Enables, flushes and forwarding selects are combinational from inputs and current state. Zero latency; they act at the same clock edge.
- While reset_ni=0: all enables 0, flushes 0, fwd selects 00. At the edge, state←RUN, wait_cnt←0, mem_timeout_o←0, counters←0.
- Reset mid-MEM_WAIT: returns to RUN. No timeout flagged.
- Ack in the same cycle as a new request in RUN: no freeze, state stays RUN.
- Maximum consecutive frozen cycles per access: MEM_TIMEOUT. The next cycle releases the pipe. mem_timeout_o reads 1 from the following cycle and stays 1 until reset.
- Back-to-back accesses: a release cycle followed by a new unacked request re-enters MEM_WAIT with wait_cnt=0.

## Test plan
- Load-use: EX load to x5, ID uses rs1=x5 → one cycle pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; next cycle all enables 1. With rd=x0 → no stall.
- Redirect while load-use pending → if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1; flush_cnt_o 0→1.
- lsu_req_i held, lsu_ack_i after 3 cycles → enables 0 for 3 cycles, 1 on the ack cycle; stall_cnt_o=3; state back to RUN.
- MEM_TIMEOUT=4, no ack → 4 frozen cycles, released on the 5th; mem_timeout_o=1 afterwards; reset clears it.
- Forwarding: MEM and WB both write x7, EX rs2=x7 → fwd_b_sel_o=01. MEM writes x0 → 10 (WB x7) or 00.
- Reset asserted during MEM_WAIT → outputs forced, counters 0, state RUN after reset. Separately, preload stall_cnt_o at 0xFFFFFFFF (force) and stall one cycle → wraps to 0.
